// File: rtl/cache_control.sv
// Sequencing controller for a 2-way set-associative L1 cache: hit service, dirty-victim
// writeback, line refill, datapath load/select generation and saturating hit/miss counters.
module cache_control #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             ishit0,
  input  logic             ishit1,
  input  logic             lru_out,
  input  logic             dirty0_out,
  input  logic             dirty1_out,
  input  logic             pmem_resp,
  output logic             mem_resp,
  output logic             pmem_read,
  output logic             pmem_write,
  output logic             pmem_addr_sel,
  output logic             datain_sel,
  output logic             load_way0,
  output logic             load_way1,
  output logic             dirty_in,
  output logic             load_lru,
  output logic             lru_in,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  typedef enum logic [1:0] {StIdle, StWriteback, StAllocate} state_e;

  state_e           state_q, state_d;
  logic             refill_q, refill_d;
  logic [CNT_W-1:0] hit_q, hit_d;
  logic [CNT_W-1:0] miss_q, miss_d;

  logic req;
  logic is_write;
  logic hit;
  logic hit_way1;
  logic victim_dirty;
  logic miss_start;

  assign req          = mem_read | mem_write;
  assign is_write     = mem_write;
  assign hit          = ishit0 | ishit1;
  // Way0 wins when both ways report a hit.
  assign hit_way1     = ~ishit0;
  assign victim_dirty = lru_out ? dirty1_out : dirty0_out;

  always_comb begin
    state_d       = state_q;
    miss_start    = 1'b0;
    mem_resp      = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    pmem_addr_sel = 1'b0;
    datain_sel    = 1'b0;
    load_way0     = 1'b0;
    load_way1     = 1'b0;
    dirty_in      = 1'b0;
    load_lru      = 1'b0;
    lru_in        = 1'b0;

    case (state_q)
      StIdle: begin
        if (req) begin
          if (hit) begin
            mem_resp = 1'b1;
            load_lru = 1'b1;
            lru_in   = ~hit_way1;
            if (is_write) begin
              load_way0 = ~hit_way1;
              load_way1 = hit_way1;
              dirty_in  = 1'b1;
            end
          end else begin
            miss_start = 1'b1;
            state_d    = victim_dirty ? StWriteback : StAllocate;
          end
        end
      end
      StWriteback: begin
        pmem_write    = 1'b1;
        pmem_addr_sel = 1'b1;
        if (pmem_resp) state_d = StAllocate;
      end
      StAllocate: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          load_way0  = ~lru_out;
          load_way1  = lru_out;
          datain_sel = 1'b1;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // The refill flag keeps the post-refill re-check from being counted as a hit.
  always_comb begin
    refill_d = refill_q;
    if (mem_resp) begin
      refill_d = 1'b0;
    end else if (state_q == StAllocate && pmem_resp) begin
      refill_d = 1'b1;
    end

    hit_d = hit_q;
    if (mem_resp && !refill_q && hit_q != '1) hit_d = hit_q + CNT_W'(1);

    miss_d = miss_q;
    if (miss_start && miss_q != '1) miss_d = miss_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      refill_q <= 1'b0;
      hit_q    <= '0;
      miss_q   <= '0;
    end else begin
      state_q  <= state_d;
      refill_q <= refill_d;
      hit_q    <= hit_d;
      miss_q   <= miss_d;
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;

endmodule

// File: doc/cache_control.md
# cache_control

Sequencing controller for the 2-way set-associative L1 cache on the LC-3b memory path. Each cycle it consumes the per-way hit flags from the tag-compare logic, plus the LRU and dirty state of the indexed set. It then services the CPU request, evicts dirty victims, refills lines from physical memory and drives every load and select in the cache datapath. It also keeps saturating hit and miss counters for performance measurement.

## Interface
Parameters:
- CNT_W, 16, width of hit_count and miss_count

Ports:
- clk  in  1  sole clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; one clock; sampled on rising edge of clk
- mem_read  in  1  CPU read request, held until mem_resp
- mem_write  in  1  CPU write request, held until mem_resp
- ishit0, ishit1  in  1  per-way hit (tag match and valid) for the current index
- lru_out  in  1  LRU bit of the indexed set; 0 means way0 is the victim, 1 means way1
- dirty0_out, dirty1_out  in  1  dirty bits of the indexed set
- pmem_resp  in  1  physical memory transfer complete, 1-cycle pulse
- mem_resp  out  1  CPU request complete
- pmem_read, pmem_write  out  1  physical memory line read / write request
- pmem_addr_sel  out  1  0 selects {CPU tag, index}; 1 selects {victim tag, index}
- datain_sel  out  1  0 selects CPU write-merged line; 1 selects pmem line
- load_way0, load_way1  out  1  write data, tag and valid=1 into that way
- dirty_in  out  1  value written to the dirty bit of the loaded way
- load_lru, lru_in  out  1  LRU write enable and value
- hit_count, miss_count  out  CNT_W  saturating performance counters

## Operation
- States: IDLE, WRITEBACK, ALLOCATE. All control outputs are combinational from the state and the inputs. Counters and refill flag are registered.
- Request definition: req = mem_read | mem_write. If both are high, the request is treated as a write.
- IDLE, no req: all outputs 0.
- IDLE, req and hit (ishit0 has priority if both are high):
  - mem_resp=1 and load_lru=1.
  - lru_in=1 on a way0 hit; lru_in=0 on a way1 hit.
  - On a write, also: load_wayN=1, datain_sel=0, dirty_in=1.
  - Stay in IDLE.
- IDLE, req and miss:
  - Victim way v = lru_out.
  - If dirty_v=1, go to WRITEBACK; otherwise go to ALLOCATE.
  - miss_count increments.
- WRITEBACK: pmem_write=1, pmem_addr_sel=1. On pmem_resp, go to ALLOCATE.
- ALLOCATE:
  - pmem_read=1, pmem_addr_sel=0.
  - On pmem_resp: load_way_v=1, datain_sel=1, dirty_in=0; set refill flag; go to IDLE.
  - The re-check in IDLE then hits and completes the request, updating LRU and merging write data.
- refill flag: cleared on mem_resp. hit_count increments on mem_resp only when the flag is clear, so refill completions are not counted as hits.
- Counters saturate at 2^CNT_W-1 and do not wrap.
- Request dropped mid-miss (req low in WRITEBACK or ALLOCATE): the transfer is still completed; the controller returns to IDLE with no mem_resp.

## Timing
- Reset values: state=IDLE, hit_count=0, miss_count=0, refill=0. Every output is 0 in the cycle after reset while req=0.
- Hit latency: mem_resp is asserted in the same cycle the request is presented.
- Clean miss: mem_resp arrives 1 cycle after the ALLOCATE pmem_resp.
- Dirty miss: adds the WRITEBACK transfer first. pmem_read is never asserted in the same cycle as pmem_write.
- pmem_read and pmem_write are held high until pmem_resp. A pmem_resp in IDLE is ignored.
- Reset mid-miss: the state returns to IDLE at the edge, and pmem_read/pmem_write are low in the following cycle. Counters clear.
- Both counters saturating in the same cycle: each holds independently.

## Test plan
- Reset, then a read with ishit1=1 -> mem_resp=1 same cycle, load_lru=1, lru_in=0, hit_count=1, miss_count=0.
- Write hit on way0 -> load_way0=1, datain_sel=0, dirty_in=1, lru_in=1, mem_resp=1.
- Read miss with lru_out=1, dirty1_out=0, pmem_resp after 4 cycles -> pmem_read high 4 cycles; load_way1=1 with dirty_in=0; mem_resp on the next cycle; miss_count=1, hit_count=0.
- Write miss with lru_out=0, dirty0_out=1 -> pmem_write with pmem_addr_sel=1 until pmem_resp, then pmem_read with pmem_addr_sel=0; final cycle has load_way0=1, dirty_in=1, mem_resp=1.
- Assert reset during ALLOCATE -> next cycle pmem_read=0, state IDLE, counters 0; a later pmem_resp produces no loads.
- Force hit_count to 0xFFFF via 65535 read hits, then one more hit -> hit_count stays 0xFFFF.
